// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the five-stage pipeline datapath and hazard_ctrl.
// The pipeline side holds the master modport; the controller holds the slave modport.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E;
  logic [4:0]       RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic             ResultSrcE0;
  logic             PCSrcE;
  logic             MemAccessM;
  logic             MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE, FlushW;
  logic             MemErr;
  logic [CNT_W-1:0] StallCycles;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemAccessM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemErr, StallCycles
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemAccessM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemErr, StallCycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and branch handling,
// data-memory wait FSM with sticky timeout error, and a saturating stall counter.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave hz
);

  localparam int WCNT_W = $clog2(MEM_TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, ERR} memState_t;

  memState_t         state, stateNext;
  logic [WCNT_W-1:0] waitCnt, waitCntNext;
  logic [CNT_W-1:0]  stallCycles;
  logic              memErr;
  logic              lwStall, memStall;

  function automatic logic [1:0] fwdSel(input logic [4:0] rs, input logic regWriteM,
                                        input logic [4:0] rdM, input logic regWriteW,
                                        input logic [4:0] rdW);
    if (regWriteM && rdM != 5'd0 && rdM == rs)      return 2'b10;
    else if (regWriteW && rdW != 5'd0 && rdW == rs) return 2'b01;
    else                                            return 2'b00;
  endfunction

  assign hz.ForwardAE = fwdSel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign hz.ForwardBE = fwdSel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

  assign lwStall = hz.ResultSrcE0 && hz.RdE != 5'd0 &&
                   (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);

  // Memory wait FSM: next state, wait counter and the freeze request
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    memStall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hz.MemAccessM && !hz.MemReadyM) begin
          memStall    = 1'b1;
          stateNext   = WAIT;
          waitCntNext = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (hz.MemReadyM) begin
          stateNext   = IDLE;
          waitCntNext = '0;
        end else begin
          memStall = 1'b1;
          if (waitCnt == WCNT_W'(MEM_TIMEOUT - 1)) stateNext = ERR;
          else                                      waitCntNext = waitCnt + 1'b1;
        end
      end
      ERR: begin
        memStall = 1'b1;
      end
      default: begin
        stateNext   = IDLE;
        waitCntNext = '0;
      end
    endcase
  end

  // Output priority: memory freeze, then taken branch, then load-use
  always_comb begin
    hz.StallF = 1'b0;
    hz.StallD = 1'b0;
    hz.StallE = 1'b0;
    hz.StallM = 1'b0;
    hz.FlushD = 1'b0;
    hz.FlushE = 1'b0;
    hz.FlushW = 1'b0;
    if (memStall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (hz.PCSrcE) begin
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (lwStall) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  // Sticky error and saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memErr      <= 1'b0;
      stallCycles <= '0;
    end else begin
      if (stateNext == ERR) memErr <= 1'b1;
      if (hz.StallF && stallCycles != {CNT_W{1'b1}}) stallCycles <= stallCycles + 1'b1;
    end
  end

  assign hz.MemErr      = memErr;
  assign hz.StallCycles = stallCycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
module tb_hazard_ctrl;
  localparam int MT = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hif ();
  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .hz(hif.slave));

  int nCmp = 0;
  int nMis = 0;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [6:0] ctl;
  assign ctl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE, hif.FlushW};

  localparam logic [6:0] CTL_NONE = 7'b0000_000;
  localparam logic [6:0] CTL_LW   = 7'b1100_010;
  localparam logic [6:0] CTL_BR   = 7'b0000_110;
  localparam logic [6:0] CTL_MEM  = 7'b1111_001;

  task automatic clearInputs();
    hif.Rs1D = 0; hif.Rs2D = 0; hif.Rs1E = 0; hif.Rs2E = 0;
    hif.RdE = 0; hif.RdM = 0; hif.RdW = 0;
    hif.RegWriteM = 0; hif.RegWriteW = 0; hif.ResultSrcE0 = 0;
    hif.PCSrcE = 0; hif.MemAccessM = 0; hif.MemReadyM = 0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    clearInputs();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst_n = 1'b0;
    #1;
    nCmp++; if (ctl !== CTL_NONE) begin nMis++; $display("FAIL reset_ctl got %b want %b", ctl, CTL_NONE); end
    nCmp++; if (hif.MemErr !== 1'b0) begin nMis++; $display("FAIL reset_memerr got %b want 0", hif.MemErr); end
    nCmp++; if (hif.StallCycles !== 4'd0) begin nMis++; $display("FAIL reset_cnt got %0d want 0", hif.StallCycles); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    hif.RdM = 5; hif.RegWriteM = 1; hif.RdW = 5; hif.RegWriteW = 1; hif.Rs1E = 5; hif.Rs2E = 5;
    #1;
    nCmp++; if (hif.ForwardAE !== 2'b10) begin nMis++; $display("FAIL fwd_a_m got %b want 10", hif.ForwardAE); end
    nCmp++; if (hif.ForwardBE !== 2'b10) begin nMis++; $display("FAIL fwd_b_m got %b want 10", hif.ForwardBE); end
    hif.RegWriteM = 0;
    #1;
    nCmp++; if (hif.ForwardAE !== 2'b01) begin nMis++; $display("FAIL fwd_a_w got %b want 01", hif.ForwardAE); end
    hif.RegWriteM = 1; hif.RdM = 0; hif.RdW = 0;
    #1;
    nCmp++; if (hif.ForwardAE !== 2'b00) begin nMis++; $display("FAIL fwd_a_x0 got %b want 00", hif.ForwardAE); end
    hif.RdM = 3; hif.RdW = 4; hif.Rs1E = 4; hif.Rs2E = 3;
    #1;
    nCmp++; if (hif.ForwardAE !== 2'b01) begin nMis++; $display("FAIL fwd_a_split got %b want 01", hif.ForwardAE); end
    nCmp++; if (hif.ForwardBE !== 2'b10) begin nMis++; $display("FAIL fwd_b_split got %b want 10", hif.ForwardBE); end
    nCmp++; if (ctl !== CTL_NONE) begin nMis++; $display("FAIL fwd_ctl got %b want %b", ctl, CTL_NONE); end
    clearInputs();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    hif.ResultSrcE0 = 1; hif.RdE = 7; hif.Rs2D = 7;
    #1;
    nCmp++; if (ctl !== CTL_LW) begin nMis++; $display("FAIL lw_ctl got %b want %b", ctl, CTL_LW); end
    @(posedge clk); #1;
    nCmp++; if (hif.StallCycles !== 4'd1) begin nMis++; $display("FAIL lw_cnt got %0d want 1", hif.StallCycles); end
    @(negedge clk);
    hif.ResultSrcE0 = 0;
    #1;
    nCmp++; if (ctl !== CTL_NONE) begin nMis++; $display("FAIL lw_release got %b want %b", ctl, CTL_NONE); end
    hif.ResultSrcE0 = 1; hif.RdE = 0; hif.Rs1D = 0; hif.Rs2D = 0;
    #1;
    nCmp++; if (ctl !== CTL_NONE) begin nMis++; $display("FAIL lw_x0 got %b want %b", ctl, CTL_NONE); end
    clearInputs();
  endtask

  task automatic test_branch_priority();
    @(negedge clk);
    hif.ResultSrcE0 = 1; hif.RdE = 9; hif.Rs1D = 9; hif.PCSrcE = 1;
    #1;
    nCmp++; if (ctl !== CTL_BR) begin nMis++; $display("FAIL br_ctl got %b want %b", ctl, CTL_BR); end
    @(posedge clk); #1;
    nCmp++; if (hif.StallCycles !== 4'd1) begin nMis++; $display("FAIL br_cnt got %0d want 1", hif.StallCycles); end
    clearInputs();
  endtask

  task automatic test_mem_wait();
    pulseReset();
    @(negedge clk);
    hif.MemAccessM = 1; hif.MemReadyM = 0; hif.PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      nCmp++; if (ctl !== CTL_MEM) begin nMis++; $display("FAIL mw_stall%0d got %b want %b", i, ctl, CTL_MEM); end
      @(negedge clk);
    end
    hif.MemReadyM = 1;
    #1;
    nCmp++; if (ctl !== CTL_BR) begin nMis++; $display("FAIL mw_ready_br got %b want %b", ctl, CTL_BR); end
    @(negedge clk);
    hif.MemAccessM = 0; hif.PCSrcE = 0; hif.MemReadyM = 0;
    #1;
    nCmp++; if (ctl !== CTL_NONE) begin nMis++; $display("FAIL mw_idle got %b want %b", ctl, CTL_NONE); end
    nCmp++; if (hif.MemErr !== 1'b0) begin nMis++; $display("FAIL mw_err got %b want 0", hif.MemErr); end
    nCmp++; if (hif.StallCycles !== 4'd3) begin nMis++; $display("FAIL mw_cnt got %0d want 3", hif.StallCycles); end
    hif.MemAccessM = 1; hif.MemReadyM = 1;
    #1;
    nCmp++; if (ctl !== CTL_NONE) begin nMis++; $display("FAIL mw_fast got %b want %b", ctl, CTL_NONE); end
    @(posedge clk); #1;
    nCmp++; if (hif.StallCycles !== 4'd3) begin nMis++; $display("FAIL mw_fast_cnt got %0d want 3", hif.StallCycles); end
    clearInputs();
  endtask

  task automatic test_timeout();
    pulseReset();
    @(negedge clk);
    hif.MemAccessM = 1; hif.MemReadyM = 0;
    for (int i = 0; i < MT; i++) begin
      #1;
      nCmp++; if (hif.MemErr !== 1'b0) begin nMis++; $display("FAIL to_early%0d got %b want 0", i, hif.MemErr); end
      @(negedge clk);
    end
    nCmp++; if (hif.MemErr !== 1'b1) begin nMis++; $display("FAIL to_err got %b want 1", hif.MemErr); end
    nCmp++; if (hif.StallCycles !== 4'd4) begin nMis++; $display("FAIL to_cnt got %0d want 4", hif.StallCycles); end
    hif.MemReadyM = 1;
    #1;
    nCmp++; if (ctl !== CTL_MEM) begin nMis++; $display("FAIL to_hold got %b want %b", ctl, CTL_MEM); end
    @(negedge clk);
    nCmp++; if (hif.MemErr !== 1'b1) begin nMis++; $display("FAIL to_sticky got %b want 1", hif.MemErr); end
    #2 rst_n = 1'b0;
    #1;
    nCmp++; if (hif.MemErr !== 1'b0) begin nMis++; $display("FAIL to_rst_err got %b want 0", hif.MemErr); end
    nCmp++; if (hif.StallCycles !== 4'd0) begin nMis++; $display("FAIL to_rst_cnt got %0d want 0", hif.StallCycles); end
    nCmp++; if (ctl !== CTL_NONE) begin nMis++; $display("FAIL to_rst_ctl got %b want %b", ctl, CTL_NONE); end
    @(negedge clk);
    rst_n = 1'b1;
    clearInputs();
  endtask

  task automatic test_saturation();
    pulseReset();
    @(negedge clk);
    hif.ResultSrcE0 = 1; hif.RdE = 12; hif.Rs1D = 12;
    repeat (15) @(posedge clk);
    #1;
    nCmp++; if (hif.StallCycles !== 4'd15) begin nMis++; $display("FAIL sat_full got %0d want 15", hif.StallCycles); end
    repeat ((1 << CW) + 5 - 15) @(posedge clk);
    #1;
    nCmp++; if (hif.StallCycles !== 4'd15) begin nMis++; $display("FAIL sat_hold got %0d want 15", hif.StallCycles); end
    clearInputs();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end
endmodule
